keypad_key_fifo: RTL and testbench

KEYPAD_KEY_FIFO -- requirements
Module: keypad_key_fifo

---
 rtl/keypad_key_fifo.sv | 164 ++++++++++++++++
 tb/tb_keypad_key_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_fifo.sv
// Keypad debouncer feeding a small first-word-fall-through key FIFO with sticky overflow.
// Define KEYPAD_FIFO_AUTOREPEAT_EN to re-push a held key every REPEAT_CYCLES cycles.
module keypad_key_fifo #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned REPEAT_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic [4:0] count,
  output logic       overflow
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [7:0]  DebLast  = 8'(DEBOUNCE_CYCLES);
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || DEPTH < 2 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_key_fifo: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

  state_e     state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic       push_req;

`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
  localparam int unsigned       RptW    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RptW-1:0]   RptLast = RptW'(REPEAT_CYCLES);
  logic [RptW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
    rpt_d    = rpt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (key_code != 8'd0) begin
          cand_d  = key_code;
          cnt_d   = 8'd1;
          state_d = StPressWait;
        end
      end
      StPressWait: begin
        if (key_code == cand_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == DebLast) begin
            push_req = 1'b1;
            cnt_d    = 8'd0;
            state_d  = StHeld;
`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
            rpt_d    = '0;
`endif
          end
        end else if (key_code == 8'd0) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cand_d = key_code;
          cnt_d  = 8'd1;
        end
      end
      StHeld: begin
        if (key_code != cand_q) begin
          cnt_d   = 8'd1;
          state_d = StReleaseWait;
        end else begin
`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
          if (rpt_q + RptW'(1) == RptLast) begin
            push_req = 1'b1;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_q + RptW'(1);
          end
`endif
        end
      end
      StReleaseWait: begin
        // The repeat counter is left untouched here so a brief glitch resumes the period.
        if (key_code == cand_q) begin
          cnt_d   = 8'd0;
          state_d = StHeld;
        end else if (cnt_q + 8'd1 == DebLast) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            empty_q, full_q, overflow_q;
  logic            pop, do_push, ovf_set;

  always_comb begin
    pop     = rd_en & ~empty_q;
    do_push = push_req & (~full_q | pop);
    ovf_set = push_req & full_q & ~pop;
    count_d = count_q + 5'(do_push) - 5'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cand_q     <= 8'd0;
      cnt_q      <= 8'd0;
`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
      rpt_q      <= '0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      empty_q <= (count_d == 5'd0);
      full_q  <= (count_d == DepthCnt);
      if (ovf_set)      overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: reads are masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= cand_q;
  end

  assign rd_data  = empty_q ? 8'd0 : mem_q[rd_ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Scoreboard bench for keypad_key_fifo: stimulus queues expected codes, a negedge monitor
// compares every accepted pop against the queue head.
module tb_keypad_key_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_code;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  keypad_key_fifo #(
    .DEBOUNCE_CYCLES(16),
    .DEPTH          (8),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_code(key_code),
    .rd_en   (rd_en),
    .clr_ovf (clr_ovf),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop is accepted at the coming edge, so compare the presented head now.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got 0x%0h, expected no entry", rd_data);
      end else begin
        check("pop_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    key_code = code;
    repeat (16) step();
    key_code = 8'd0;
    repeat (16) step();
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) step();
    rd_en = 1'b0;
  endtask

  initial begin
    logic saw_data;
    logic [7:0] s;
    rst      = 1'b1;
    key_code = 8'd0;
    rd_en    = 1'b0;
    clr_ovf  = 1'b0;
    repeat (2) step();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step();

    // Single press: push lands on the 16th sampling edge.
    key_code = 8'h35;
    repeat (15) step();
    check("press_edge15_empty", empty, 1);
    step();
    check("press_edge16_empty", empty, 0);
    check("press_edge16_count", count, 1);
    exp_q.push_back(8'h35);
    key_code = 8'd0;
    repeat (16) step();
    check("press_release_count", count, 1);
    pop_n(1);
    check("press_drained", empty, 1);

    // Bounce: 5-cycle bursts never reach the debounce threshold.
    saw_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      key_code = (i % 2 == 0) ? 8'h35 : 8'h00;
      repeat (5) begin
        step();
        saw_data |= ~empty;
      end
    end
    check("bounce_no_push", saw_data, 0);
    key_code = 8'd0;
    repeat (16) step();
    press(8'h35);
    exp_q.push_back(8'h35);
    check("bounce_then_stable_count", count, 1);
    pop_n(1);

    // Overflow: nine presses into an 8-entry FIFO.
    for (int i = 0; i < 9; i++) begin
      s = 8'h31 + 8'(i);
      press(s);
      if (i < 8) exp_q.push_back(s);
    end
    check("ovf_count", count, 8);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    pop_n(8);
    check("ovf_drained_empty", empty, 1);
    check("ovf_drained_full", full, 0);
    pop_n(1);
    check("pop_when_empty_count", count, 0);
    check("ovf_still_set", overflow, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 8; i++) begin
      s = 8'h61 + 8'(i);
      press(s);
      exp_q.push_back(s);
    end
    check("sim_full_before", full, 1);
    key_code = 8'h7a;
    exp_q.push_back(8'h7a);
    repeat (15) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("sim_count", count, 8);
    check("sim_overflow", overflow, 0);
    check("sim_full_after", full, 1);
    key_code = 8'd0;
    repeat (16) step();
    pop_n(8);
    check("sim_drained", empty, 1);

    // Reset with entries queued and a key held.
    press(8'h70);
    press(8'h71);
    press(8'h72);
    check("rstmid_count_before", count, 3);
    key_code = 8'h41;
    repeat (5) step();
    rst = 1'b1;
    step();
    exp_q.delete();
    check("rstmid_count", count, 0);
    check("rstmid_empty", empty, 1);
    rst = 1'b0;
    repeat (15) step();
    check("rstmid_edge15_empty", empty, 1);
    step();
    check("rstmid_edge16_count", count, 1);
    exp_q.push_back(8'h41);
    repeat (10) step();
    key_code = 8'd0;
    repeat (16) step();
    check("rstmid_single_push", count, 1);
    pop_n(1);

`ifdef KEYPAD_FIFO_AUTOREPEAT_EN
    // Auto-repeat: pushes at edges 16, 48, 80 and 112 of a 116-cycle hold.
    key_code = 8'h23;
    repeat (116) step();
    key_code = 8'd0;
    repeat (16) step();
    check("repeat_count", count, 4);
    repeat (4) exp_q.push_back(8'h23);
    pop_n(4);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
